// File: rtl/rr_arb4_ctrl_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: requester count and FSM state encoding.
package rr_arb4_ctrl_pkg;

  localparam int REQ_N = 4;

  // State encoding is kept as plain constants so older flows that expect
  // a 1-bit state register can consume the netlist unchanged.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arb4_ctrl_onehot_enc4.sv
// Encodes a 4-bit one-hot vector to its 2-bit index; 0000 encodes as 0.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: onehot (in, 4) -> idx (out, 2).
module onehot_enc4 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  // Valid only for one-hot or zero inputs, which is all the arbiter produces.
  assign idx = {onehot[3] | onehot[2], onehot[3] | onehot[1]};

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter sharing one resource among 4 level requesters, with a
// tenure limit so a busy owner cannot starve other waiting requesters.
// Latency: req -> registered gnt one cycle later; release hands over with no bubble.
// Backpressure: requesters hold req until granted; a lone requester may keep grant.
// Ports: clk, rst_n (async, active-low), req[4] in; gnt[4], gnt_idx[2],
//        gnt_valid, hold_cnt[CNT_W] out.
module rr_arb4_ctrl
  import rr_arb4_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_N-1:0]     req,
  output logic [REQ_N-1:0]     gnt,
  output logic [1:0]           gnt_idx,
  output logic                 gnt_valid,
  output logic [CNT_W-1:0]     hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [REQ_N-1:0] gnt_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [REQ_N-1:0] others;
  logic [1:0]       owner_inc;

  // First set bit of r, scanning start, start+1, ... with 2-bit wrap.
  function automatic logic [1:0] rr_pick(input logic [REQ_N-1:0] r,
                                         input logic [1:0]       start);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  onehot_enc4 u_enc (
    .onehot (gnt),
    .idx    (gnt_idx)
  );

  assign gnt_valid = |gnt;
  // The owner is excluded so a forced rotation can never re-pick it.
  assign others    = req & ~gnt;
  assign owner_inc = gnt_idx + 2'd1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    cnt_nxt   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = REQ_N'(1) << rr_pick(req, ptr);
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (!req[gnt_idx]) begin
          // Release wins over a simultaneous limit hit.
          ptr_nxt = owner_inc;
          cnt_nxt = '0;
          if (|others) begin
            gnt_nxt = REQ_N'(1) << rr_pick(others, owner_inc);
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
          end
        end else if ((hold_cnt == HOLD_LAST) && (|others)) begin
          ptr_nxt = owner_inc;
          cnt_nxt = '0;
          gnt_nxt = REQ_N'(1) << rr_pick(others, owner_inc);
        end else if (hold_cnt != HOLD_LAST) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Scoreboard bench for rr_arb4_ctrl: driver applies req at the falling edge and
// queues the model's prediction; monitor pops and compares after each rising edge.
module tb_rr_arb4_ctrl;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  typedef struct {
    logic [3:0]       gnt;
    logic [1:0]       idx;
    logic             vld;
    logic [CNT_W-1:0] hold;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Reference model: owner number (-1 when idle), tenure length, search start.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] o;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = first_from(r, m_ptr);
        m_hold  = 0;
      end
    end else begin
      o = r;
      o[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = first_from(o, m_ptr);
        m_hold  = 0;
      end else if (m_hold == MAX_HOLD - 1 && o != 4'b0000) begin
        m_owner = first_from(o, (m_owner + 1) % 4);
        m_hold  = 0;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic step(input logic [3:0] r, input logic rn);
    exp_t e;
    @(negedge clk);
    req   = r;
    rst_n = rn;
    if (!rn) model_reset();
    else     model_step(r);
    e.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.idx  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.vld  = (m_owner >= 0);
    e.hold = CNT_W'(m_hold);
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a registered result every cycle.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",       int'(gnt),       int'(e.gnt));
      chk("gnt_idx",   int'(gnt_idx),   int'(e.idx));
      chk("gnt_valid", int'(gnt_valid), int'(e.vld));
      chk("hold_cnt",  int'(hold_cnt),  int'(e.hold));
    end
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    chk("reset_gnt",       int'(gnt),       0);
    chk("reset_gnt_idx",   int'(gnt_idx),   0);
    chk("reset_gnt_valid", int'(gnt_valid), 0);
    chk("reset_hold_cnt",  int'(hold_cnt),  0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);

    // Lone requester 2: immediate grant, then saturating tenure.
    step(4'b0100, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b0100, 1'b1);
    @(negedge clk);
    chk("single_hold_sat", int'(hold_cnt), 7);
    chk("single_gnt",      int'(gnt),      4);

    // Fairness: every owner drops its request in its second granted cycle.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_hold == 1) r[m_owner] = 1'b0;
      step(r, 1'b1);
    end

    // Hold limit with two persistent requesters.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 40; i++) step(4'b0011, 1'b1);

    // Wrap: owner 3 releases while 0 and 2 wait.
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0101, 1'b1);
    @(negedge clk);
    chk("wrap_gnt", int'(gnt), 1);

    // Mid-tenure asynchronous reset, then ptr=0 search on release.
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    @(posedge clk);
    #3;
    chk("pre_async_gnt", int'(gnt), 2);
    rst_n = 1'b0;
    #1;
    chk("async_gnt",       int'(gnt),       0);
    chk("async_gnt_idx",   int'(gnt_idx),   0);
    chk("async_gnt_valid", int'(gnt_valid), 0);
    chk("async_hold_cnt",  int'(hold_cnt),  0);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);

    // Random level requests: waiters stay asserted, owners drop at random.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if (m_owner >= 0 && r[m_owner] && $urandom_range(3) == 0) r[m_owner] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (!r[b] && b != m_owner && $urandom_range(2) == 0) r[b] = 1'b1;
      end
      step(r, (i % 211 == 210) ? 1'b0 : 1'b1);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
